mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port `Memory` block between the instruction-fetch path and the load/store path of the core. One access is issued per cycle with a fixed data-port priority, bounded by an anti-starvation counter for fetch. Alignment and size are checked before issue. Each granted access returns a registered response one cycle later. It sits between the pipeline front/back ends and the `Memory` instance, driving its `address`, `wr_data`, `wr_enable` and `write_length` inputs.

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch and load/store.
// Data port has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT denials.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_valid,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_enable,
    output logic [2:0]  mem_write_length,
    input  logic [31:0] mem_read_data
);

    logic [CNT_W-1:0] r_starveCnt;
    logic             w_starved;
    logic             w_grantD;
    logic             w_grantI;
    logic             w_dBad;
    logic             w_iBad;

    assign w_starved = (r_starveCnt >= CNT_W'(STARVE_LIMIT));

    // Grants are gated by rst_n so nothing reaches memory while reset is held.
    assign w_grantD = rst_n && d_valid && !(i_valid && w_starved);
    assign w_grantI = rst_n && i_valid && !w_grantD;

    assign d_ready = w_grantD;
    assign i_ready = w_grantI;

    assign w_dBad = (d_size > 3'd2)
                 || ((d_size == 3'd1) && d_addr[0])
                 || ((d_size == 3'd2) && (d_addr[1:0] != 2'b00));
    assign w_iBad = (i_addr[1:0] != 2'b00);

    always_comb begin
        mem_address      = 32'd0;
        mem_wr_data      = 32'd0;
        mem_wr_enable    = 1'b0;
        mem_write_length = 3'd2;
        if (w_grantD) begin
            mem_address      = d_addr;
            mem_wr_data      = d_wdata;
            mem_wr_enable    = d_we && !w_dBad;
            mem_write_length = d_size;
        end else if (w_grantI) begin
            mem_address      = i_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starveCnt <= '0;
        end else if (!i_valid || w_grantI) begin
            r_starveCnt <= '0;
        end else if (!w_starved) begin
            r_starveCnt <= r_starveCnt + CNT_W'(1);
        end
    end

    // Responses for stores and faulty accesses carry zero data so nothing stale leaks downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rvalid <= 1'b0;
            d_rdata  <= 32'd0;
            d_err    <= 1'b0;
        end else if (w_grantD) begin
            d_rvalid <= 1'b1;
            d_rdata  <= (d_we || w_dBad) ? 32'd0 : mem_read_data;
            d_err    <= w_dBad;
        end else begin
            d_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            i_rdata  <= 32'd0;
            i_err    <= 1'b0;
        end else if (w_grantI) begin
            i_rvalid <= 1'b1;
            i_rdata  <= w_iBad ? 32'd0 : mem_read_data;
            i_err    <= w_iBad;
        end else begin
            i_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte-addressed memory model and an independent reference image.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_valid;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic        mem_wr_enable;
    logic [2:0]  mem_write_length;
    logic [31:0] mem_read_data;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t      dExp[$];
    resp_t      iExp[$];
    logic [7:0] memBytes [256];
    logic [7:0] refMem   [256];
    int         compared   = 0;
    int         mismatched = 0;
    logic       dPend      = 1'b0;
    logic       iPend      = 1'b0;
    int         tbCnt      = 0;
    logic       lastIReady = 1'b0;
    logic [11:0] fetchWins;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_wr_data(mem_wr_data),
        .mem_wr_enable(mem_wr_enable), .mem_write_length(mem_write_length),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory block stand-in: combinational little-endian read, write on the rising edge.
    assign mem_read_data = {memBytes[mem_address[7:0] + 8'd3], memBytes[mem_address[7:0] + 8'd2],
                            memBytes[mem_address[7:0] + 8'd1], memBytes[mem_address[7:0]]};

    always @(posedge clk) begin
        if (mem_wr_enable) begin
            memBytes[mem_address[7:0]] <= mem_wr_data[7:0];
            if (mem_write_length != 3'd0) begin
                memBytes[mem_address[7:0] + 8'd1] <= mem_wr_data[15:8];
            end
            if (mem_write_length == 3'd2) begin
                memBytes[mem_address[7:0] + 8'd2] <= mem_wr_data[23:16];
                memBytes[mem_address[7:0] + 8'd3] <= mem_wr_data[31:24];
            end
        end
    end

    function automatic logic [31:0] refWord(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {refMem[b + 8'd3], refMem[b + 8'd2], refMem[b + 8'd1], refMem[b]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One cycle: drive at posedge+1, check last cycle's responses and this cycle's grants at negedge.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic dv, input logic dwe,
                                 input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] ds);
        logic       expD;
        logic       expI;
        logic       bad;
        logic [7:0] b;
        resp_t      r;
        i_valid = iv;
        i_addr  = ia;
        d_valid = dv;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_size  = ds;
        @(negedge clk);
        checkOutput("d_rvalid", 32'(d_rvalid), 32'(dPend));
        if (dPend && dExp.size() > 0) begin
            r = dExp.pop_front();
            checkOutput("d_rdata", d_rdata, r.data);
            checkOutput("d_err", 32'(d_err), 32'(r.err));
        end
        checkOutput("i_rvalid", 32'(i_rvalid), 32'(iPend));
        if (iPend && iExp.size() > 0) begin
            r = iExp.pop_front();
            checkOutput("i_rdata", i_rdata, r.data);
            checkOutput("i_err", 32'(i_err), 32'(r.err));
        end
        expD = dv && !(iv && tbCnt >= 4);
        expI = iv && !expD;
        lastIReady = i_ready;
        checkOutput("d_ready", 32'(d_ready), 32'(expD));
        checkOutput("i_ready", 32'(i_ready), 32'(expI));
        if (!expD && !expI) begin
            checkOutput("idle_addr", mem_address, 32'd0);
            checkOutput("idle_we", 32'(mem_wr_enable), 32'd0);
        end
        if (expD) begin
            bad = (ds > 3'd2) || (ds == 3'd1 && da[0]) || (ds == 3'd2 && da[1:0] != 2'b00);
            r.err  = bad;
            r.data = (dwe || bad) ? 32'd0 : refWord(da);
            dExp.push_back(r);
            if (dwe && !bad) begin
                b = da[7:0];
                refMem[b] = dwd[7:0];
                if (ds != 3'd0) refMem[b + 8'd1] = dwd[15:8];
                if (ds == 3'd2) begin
                    refMem[b + 8'd2] = dwd[23:16];
                    refMem[b + 8'd3] = dwd[31:24];
                end
            end
        end
        if (expI) begin
            r.err  = (ia[1:0] != 2'b00);
            r.data = r.err ? 32'd0 : refWord(ia);
            iExp.push_back(r);
        end
        dPend = expD;
        iPend = expI;
        if (!iv || expI) tbCnt = 0;
        else if (tbCnt < 4) tbCnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            memBytes[k] = 8'd0;
            refMem[k]   = 8'd0;
        end
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_addr  = 32'd0;
        d_valid = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'd0;
        d_wdata = 32'h89ABCDEF;
        d_size  = 3'd2;
        fetchWins = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_d_ready", 32'(d_ready), 32'd0);
        checkOutput("rst_i_ready", 32'(i_ready), 32'd0);
        checkOutput("rst_we", 32'(mem_wr_enable), 32'd0);
        checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        checkOutput("rst_d_err", 32'(d_err), 32'd0);
        checkOutput("rst_i_err", 32'(i_err), 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 32'd0);
        checkOutput("rst_i_rdata", i_rdata, 32'd0);
        d_valid = 1'b0;
        d_we    = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset write suppression and word store/load");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 32'h12345678, 3'd2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 3'd2);
        idleCycle();

        $display("[TB] byte and halfword stores");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 32'h000000EF, 3'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'h000000AD, 3'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd6, 32'h000000BD, 3'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd7, 32'h000000AB, 3'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 3'd2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd36, 32'h1234ABCD, 3'd2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd36, 32'h0000EFDA, 3'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd36, 32'd0, 3'd2);
        idleCycle();

        $display("[TB] alignment and size errors");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 3'd2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 3'd2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'd37, 32'h00005555, 3'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd36, 32'd0, 3'd2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd3);
        applyStimulus(1'b1, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        applyStimulus(1'b1, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        idleCycle();

        $display("[TB] continuous contention");
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'd8, 32'd0, 3'd2);
            fetchWins[c] = lastIReady;
        end
        checkOutput("fetch_win_pattern", 32'(fetchWins), 32'h210);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'd8, 32'd0, 3'd2);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'd8, 32'd0, 3'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("midrst_d_ready", 32'(d_ready), 32'd0);
        checkOutput("midrst_i_ready", 32'(i_ready), 32'd0);
        i_valid = 1'b0;
        d_valid = 1'b0;
        dExp.delete();
        iExp.delete();
        dPend = 1'b0;
        iPend = 1'b0;
        tbCnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fetchWins = '0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'd8, 32'd0, 3'd2);
            fetchWins[c] = lastIReady;
        end
        checkOutput("post_rst_wins", 32'(fetchWins), 32'h010);
        idleCycle();
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
